// File: rtl/rx_bit_recovery.sv
// rx_bit_recovery: receive-side bit timing recovery.
// Resynchronises a per-bit counter on every line edge, samples the line at
// mid-bit, NRZI-decodes the samples and (optionally) removes stuffed bits.
// Optional feature macro: RX_BIT_RECOVERY_UNSTUFF_EN
//   defined   -> stuffed-zero removal and stuff_err_o reporting
//   undefined -> every sample is emitted directly, stuff_err_o is tied to 0
module rx_bit_recovery #(
  parameter int   CLKS_PER_BIT = 8,
  parameter int   SAMPLE_POINT = 4,
  parameter logic IDLE_LEVEL   = 1'b1,
  parameter int   STUFF_LIMIT  = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic data_i,
  input  logic edge_found_i,
  input  logic enable_i,
  output logic bit_o,
  output logic bit_valid_o,
  output logic stuff_err_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);

  // Reject parameter sets that cannot produce a sample point inside the bit.
  if (CLKS_PER_BIT < 4 || SAMPLE_POINT < 1 || SAMPLE_POINT >= CLKS_PER_BIT ||
      STUFF_LIMIT < 1) begin : g_bad_param
    $error("rx_bit_recovery: illegal parameter combination");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_prev_level;
  logic             r_bit;
  logic             r_bit_valid;
  logic             w_sample;
  logic             w_dec;
  logic             w_emit;

  // An edge restarts the bit period, so it also suppresses a coincident sample.
  assign w_sample = enable_i & ~edge_found_i & (r_cnt == SAMPLE_CNT);
  // NRZI: no transition since the previous sample decodes as a 1.
  assign w_dec    = (data_i == r_prev_level);

  // Per-bit counter: cleared while disabled or on an edge, otherwise wraps.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (!enable_i || edge_found_i) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // NRZI reference level: last sampled level, back to idle when disabled.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_level <= IDLE_LEVEL;
    end else if (!enable_i) begin
      r_prev_level <= IDLE_LEVEL;
    end else if (w_sample) begin
      r_prev_level <= data_i;
    end
  end

`ifdef RX_BIT_RECOVERY_UNSTUFF_EN
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

  logic [ONES_W-1:0] r_ones;
  logic              r_stuff_err;
  logic              w_at_limit;
  logic              w_err;

  // After STUFF_LIMIT ones the next bit is a stuffed 0 and is never emitted;
  // a 1 in that slot is a stuffing violation.
  assign w_at_limit = (r_ones == ONES_MAX);
  assign w_emit     = w_sample & ~w_at_limit;
  assign w_err      = w_sample & w_at_limit & w_dec;

  // Run length of consecutive decoded ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ones <= '0;
    end else if (!enable_i) begin
      r_ones <= '0;
    end else if (w_sample) begin
      if (w_dec && !w_at_limit) begin
        r_ones <= r_ones + 1'b1;
      end else begin
        r_ones <= '0;
      end
    end
  end

  // Stuffing-violation strobe, one cycle wide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stuff_err <= 1'b0;
    end else begin
      r_stuff_err <= w_err;
    end
  end

  assign stuff_err_o = r_stuff_err;
`else
  assign w_emit      = w_sample;
  assign stuff_err_o = 1'b0;
`endif

  // Decoded bit and its strobe; the bit holds between strobes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_bit_valid <= w_emit;
      if (w_emit) begin
        r_bit <= w_dec;
      end
    end
  end

  assign bit_o       = r_bit;
  assign bit_valid_o = r_bit_valid;

endmodule
